// File: rtl/vga_pkg.sv
// VGA 640x480@60Hz timing constants and shared types.
// Also provides the visible-window bound calculation.
package vga_pkg;

  localparam int H_SYNC_D  = 96;
  localparam int H_BP_D    = 48;
  localparam int H_ATIVO_D = 640;
  localparam int H_FP_D    = 16;
  localparam int V_SYNC_D  = 2;
  localparam int V_BP_D    = 33;
  localparam int V_ATIVO_D = 480;
  localparam int V_FP_D    = 10;

  localparam int H_TOTAL =
    H_SYNC_D + H_BP_D + H_ATIVO_D + H_FP_D;
  localparam int V_TOTAL =
    V_SYNC_D + V_BP_D + V_ATIVO_D + V_FP_D;

  localparam int H_INICIO = H_SYNC_D + H_BP_D;
  localparam int V_INICIO = V_SYNC_D + V_BP_D;

  localparam int CONT_W   = 10;
  localparam int QUADRO_W = 16;
  localparam int CONT_MAX = 1 << CONT_W;

  // Bounds are one bit wider than the counters so an
  // end bound of exactly 1024 still fits.
  typedef struct packed {
    logic [CONT_W:0] h_ini;
    logic [CONT_W:0] h_fim;
    logic [CONT_W:0] v_ini;
    logic [CONT_W:0] v_fim;
  } janela_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } sinc_t;

  localparam sinc_t SINC_INATIVO = '{
    hs:      1'b1,
    vs:      1'b1,
    blank_n: 1'b0
  };

  function automatic janela_t calc_janela(
    input int hs,
    input int hbp,
    input int ha,
    input int vs,
    input int vbp,
    input int va
  );
    janela_t j;
    j.h_ini = (CONT_W+1)'(hs + hbp);
    j.h_fim = (CONT_W+1)'(hs + hbp + ha);
    j.v_ini = (CONT_W+1)'(vs + vbp);
    j.v_fim = (CONT_W+1)'(vs + vbp + va);
    return j;
  endfunction

endpackage

// File: rtl/linha_atraso.sv
// Fixed-depth shift register with a per-bit reset value.
// Depth 0 degenerates to a plain wire.
module linha_atraso #(
  parameter int LARGURA      = 3,
  parameter int PROFUNDIDADE = 1,
  parameter logic [LARGURA-1:0] VAL_RESET = '0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [LARGURA-1:0] i_d,
  output logic [LARGURA-1:0] o_q
);

  if (PROFUNDIDADE == 0) begin : g_direto

    assign o_q = i_d;

  end else begin : g_reg

    logic [LARGURA-1:0] r_est [PROFUNDIDADE];

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        for (int i = 0; i < PROFUNDIDADE; i++)
          r_est[i] <= VAL_RESET;
      end else begin
        r_est[0] <= i_d;
        for (int i = 1; i < PROFUNDIDADE; i++)
          r_est[i] <= r_est[i-1];
      end
    end

    assign o_q = r_est[PROFUNDIDADE-1];

  end

endmodule

// File: rtl/vga_sincronizador.sv
// VGA raster counters, sync generation and frame tick.
// Sync/blank are delayed to line up with the renderer's RGB.
module vga_sincronizador
  import vga_pkg::*;
#(
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int H_ATIVO  = H_ATIVO_D,
  parameter int H_FP     = H_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int V_ATIVO  = V_ATIVO_D,
  parameter int V_FP     = V_FP_D,
  parameter int LATENCIA = 1
) (
  input  logic                VGA_CLK,
  input  logic                reset,
  output logic [CONT_W-1:0]   VGA_X,
  output logic [CONT_W-1:0]   VGA_Y,
  output logic                ativo_video,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_BLANK_N,
  output logic                VGA_SYNC_N,
  output logic                fim_quadro,
  output logic [QUADRO_W-1:0] cont_quadro
);

  localparam int HT = H_SYNC + H_BP + H_ATIVO + H_FP;
  localparam int VT = V_SYNC + V_BP + V_ATIVO + V_FP;

  localparam janela_t JAN = calc_janela(
    H_SYNC, H_BP, H_ATIVO,
    V_SYNC, V_BP, V_ATIVO
  );

  localparam logic [CONT_W-1:0] X_ULT = CONT_W'(HT - 1);
  localparam logic [CONT_W-1:0] Y_ULT = CONT_W'(VT - 1);
  localparam logic [CONT_W-1:0] X_SYN = CONT_W'(H_SYNC);
  localparam logic [CONT_W-1:0] Y_SYN = CONT_W'(V_SYNC);

  if (HT > CONT_MAX || VT > CONT_MAX) begin : g_chk_tam
    $error("vga_sincronizador: H/V total exceeds 1024");
  end

  if (LATENCIA < 0 || LATENCIA > 4) begin : g_chk_lat
    $error("vga_sincronizador: LATENCIA must be 0..4");
  end

  logic [CONT_W-1:0]   r_x;
  logic [CONT_W-1:0]   r_y;
  logic [QUADRO_W-1:0] r_quadro;

  logic  w_fim_x;
  logic  w_fim_y;
  logic  w_fim;
  logic  w_ativo;
  sinc_t w_sinc;
  sinc_t w_sinc_atr;

  assign w_fim_x = (r_x == X_ULT);
  assign w_fim_y = (r_y == Y_ULT);
  assign w_fim   = w_fim_x && w_fim_y && reset;

  always_ff @(posedge VGA_CLK) begin
    if (!reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_fim_x) begin
      r_x <= '0;
      r_y <= w_fim_y ? '0 : r_y + 1'b1;
    end else begin
      r_x <= r_x + 1'b1;
    end
  end

  // Wraps silently at 2^16 frames.
  always_ff @(posedge VGA_CLK) begin
    if (!reset)
      r_quadro <= '0;
    else if (w_fim)
      r_quadro <= r_quadro + 1'b1;
  end

  assign w_ativo =
    ({1'b0, r_x} >= JAN.h_ini) &&
    ({1'b0, r_x} <  JAN.h_fim) &&
    ({1'b0, r_y} >= JAN.v_ini) &&
    ({1'b0, r_y} <  JAN.v_fim);

  assign w_sinc.hs      = !(r_x < X_SYN);
  assign w_sinc.vs      = !(r_y < Y_SYN);
  assign w_sinc.blank_n = w_ativo;

  linha_atraso #(
    .LARGURA      ($bits(sinc_t)),
    .PROFUNDIDADE (LATENCIA),
    .VAL_RESET    (SINC_INATIVO)
  ) u_atraso (
    .i_clk   (VGA_CLK),
    .i_rst_n (reset),
    .i_d     (w_sinc),
    .o_q     (w_sinc_atr)
  );

  assign VGA_X       = r_x;
  assign VGA_Y       = r_y;
  assign ativo_video = w_ativo;
  assign VGA_HS      = w_sinc_atr.hs;
  assign VGA_VS      = w_sinc_atr.vs;
  assign VGA_BLANK_N = w_sinc_atr.blank_n;
  assign VGA_SYNC_N  = 1'b0;
  assign fim_quadro  = w_fim;
  assign cont_quadro = r_quadro;

endmodule
